// File: rtl/cory_rdma2d_seq_if.sv
// rtl/cory_rdma2d_seq_if.sv - frame command and line command bundle for the 2D read sequencer
interface cory_rdma2d_seq_if #(
  parameter int A = 32,
  parameter int R = 11,
  parameter int H = 11
);
  logic         i_cmd_v;
  logic [R-1:0] i_cmd_width;
  logic [H-1:0] i_cmd_height;
  logic [A-1:0] i_cmd_base;
  logic [A-1:0] i_cmd_stride;
  logic         o_cmd_r;
  logic         o_line_v;
  logic [R-1:0] o_line_width;
  logic [A-1:0] o_line_base;
  logic         i_line_r;
  logic [H-1:0] o_line_idx;
  logic         o_busy;

  // master: frame controller plus line engine side; slave: the sequencer
  modport master (
    output i_cmd_v, i_cmd_width, i_cmd_height, i_cmd_base, i_cmd_stride, i_line_r,
    input  o_cmd_r, o_line_v, o_line_width, o_line_base, o_line_idx, o_busy
  );

  modport slave (
    input  i_cmd_v, i_cmd_width, i_cmd_height, i_cmd_base, i_cmd_stride, i_line_r,
    output o_cmd_r, o_line_v, o_line_width, o_line_base, o_line_idx, o_busy
  );
endinterface

// File: rtl/cory_rdma2d_seq.sv
// rtl/cory_rdma2d_seq.sv - 2D frame sequencer issuing one line command per row; CORY_RDMA2D_SEQ_PERF_EN adds o_perf_cyc
module cory_rdma2d_seq #(
  parameter int A = 32,
  parameter int R = 11,
  parameter int H = 11
) (
  input  logic             clk,
  input  logic             reset_n,
  cory_rdma2d_seq_if.slave bus
`ifdef CORY_RDMA2D_SEQ_PERF_EN
  ,
  output logic [31:0]      o_perf_cyc
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t       state;
  logic [H-1:0] height_q;
  logic [A-1:0] stride_q;
  logic         zero_size;
  logic         last_line;

  assign zero_size = (bus.i_cmd_width == '0) || (bus.i_cmd_height == '0);
  assign last_line = (bus.o_line_idx == height_q - H'(1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      height_q         <= '0;
      stride_q         <= '0;
      bus.o_cmd_r      <= 1'b0;
      bus.o_line_v     <= 1'b0;
      bus.o_busy       <= 1'b0;
      bus.o_line_base  <= '0;
      bus.o_line_width <= '0;
      bus.o_line_idx   <= '0;
    end else begin
      bus.o_cmd_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.i_cmd_v) begin
            height_q         <= bus.i_cmd_height;
            stride_q         <= bus.i_cmd_stride;
            bus.o_line_base  <= bus.i_cmd_base;
            bus.o_line_width <= bus.i_cmd_width;
            bus.o_line_idx   <= '0;
            bus.o_busy       <= 1'b1;
            if (zero_size) begin
              state       <= DONE;
              bus.o_cmd_r <= 1'b1;
            end else begin
              state        <= ISSUE;
              bus.o_line_v <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (bus.i_line_r) begin
            bus.o_line_v <= 1'b0;
            if (last_line) begin
              state       <= DONE;
              bus.o_cmd_r <= 1'b1;
            end else begin
              state <= GAP;
            end
          end
        end
        GAP: begin
          // low cycle gives the line engine a fresh rising edge of o_line_v
          bus.o_line_base <= bus.o_line_base + stride_q;
          bus.o_line_idx  <= bus.o_line_idx + H'(1);
          bus.o_line_v    <= 1'b1;
          state           <= ISSUE;
        end
        DONE: begin
          bus.o_busy <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef CORY_RDMA2D_SEQ_PERF_EN
  // the accept cycle is counted as the first cycle of the frame
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_perf_cyc <= '0;
    end else if (state == IDLE) begin
      if (bus.i_cmd_v) begin
        o_perf_cyc <= 32'd1;
      end
    end else if (o_perf_cyc != 32'hFFFF_FFFF) begin
      o_perf_cyc <= o_perf_cyc + 32'd1;
    end
  end
`endif

endmodule
